// File: rtl/eth_phy_ctrl_if.sv
// eth_phy_ctrl_if: SMI master handshake and user register-access bundle.
interface eth_phy_ctrl_if;
    logic        smi_ready;
    logic        smi_valid;
    logic        smi_write;
    logic [4:0]  smi_phyaddr;
    logic [4:0]  smi_register;
    logic [15:0] smi_write_value;
    logic [15:0] smi_read_value;
    logic        usr_valid;
    logic        usr_ready;
    logic        usr_write;
    logic [4:0]  usr_register;
    logic [15:0] usr_wdata;
    logic [15:0] usr_rdata;
    logic        usr_done;

    modport master (
        input  smi_ready, smi_read_value, usr_valid, usr_write, usr_register, usr_wdata,
        output smi_valid, smi_write, smi_phyaddr, smi_register, smi_write_value,
               usr_ready, usr_rdata, usr_done
    );

    modport slave (
        output smi_ready, smi_read_value, usr_valid, usr_write, usr_register, usr_wdata,
        input  smi_valid, smi_write, smi_phyaddr, smi_register, smi_write_value,
               usr_ready, usr_rdata, usr_done
    );
endinterface

// File: rtl/eth_phy_ctrl.sv
// eth_phy_ctrl: PHY status poller and user MDIO access arbiter on top of an SMI master.
// Define ETH_PHY_CTRL_INIT_EN to soft-reset and configure the PHY before going idle.
module eth_phy_ctrl #(
    parameter logic [4:0]  PHYADDR         = 5'd1,
    parameter logic [23:0] POLL_CYCLES     = 24'd5_000_000,
    parameter logic [23:0] RST_WAIT_CYCLES = 24'd2_500_000
) (
    input  logic           clk_mac,
    input  logic           rst,
    eth_phy_ctrl_if.master bus,
    output logic           link_up,
    output logic           speed_100,
    output logic           full_duplex,
    output logic           status_valid
);
    typedef enum logic [2:0] {INIT_RST, INIT_WAIT, INIT_CFG, IDLE, ISSUE, WAIT_LOW, WAIT_DONE} state_t;
    typedef enum logic [2:0] {OP_RST, OP_CFG, OP_BMSR, OP_PHYSTS, OP_USR} op_t;

`ifdef ETH_PHY_CTRL_INIT_EN
    localparam state_t START = INIT_RST;
`else
    localparam state_t START = IDLE;
`endif

    state_t      state_q;
    op_t         op_q;
    logic [23:0] timer_q, timer_d, wait_q;
    logic        expire, pending_q, link_tmp_q;
    logic        valid_q, write_q, done_q;
    logic [4:0]  phy_q, reg_q;
    logic [15:0] wdata_q, rdata_q;
    logic        link_q, speed_q, duplex_q, status_q;

    assign expire  = timer_q == 24'd0;
    assign timer_d = expire ? POLL_CYCLES - 24'd1 : timer_q - 24'd1;

    assign bus.smi_valid       = valid_q;
    assign bus.smi_write       = write_q;
    assign bus.smi_phyaddr     = phy_q;
    assign bus.smi_register    = reg_q;
    assign bus.smi_write_value = wdata_q;
    assign bus.usr_ready       = (state_q == IDLE) && !rst;
    assign bus.usr_rdata       = rdata_q;
    assign bus.usr_done        = done_q;
    assign link_up             = link_q;
    assign speed_100           = speed_q;
    assign full_duplex         = duplex_q;
    assign status_valid        = status_q;

    always_ff @(posedge clk_mac) begin
        if (rst) begin
            state_q    <= START;
            op_q       <= OP_USR;
            timer_q    <= POLL_CYCLES - 24'd1;
            wait_q     <= 24'd0;
            pending_q  <= 1'b1;
            link_tmp_q <= 1'b0;
            valid_q    <= 1'b0;
            write_q    <= 1'b0;
            phy_q      <= 5'd0;
            reg_q      <= 5'd0;
            wdata_q    <= 16'h0;
            rdata_q    <= 16'h0;
            done_q     <= 1'b0;
            link_q     <= 1'b0;
            speed_q    <= 1'b0;
            duplex_q   <= 1'b0;
            status_q   <= 1'b0;
        end else begin
            timer_q <= timer_d;
            phy_q   <= PHYADDR;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            if (expire) pending_q <= 1'b1;
            case (state_q)
                INIT_RST: begin
                    {write_q, reg_q, wdata_q} <= {1'b1, 5'd0, 16'h8000};
                    op_q    <= OP_RST;
                    state_q <= ISSUE;
                end
                INIT_WAIT: begin
                    wait_q <= wait_q - 24'd1;
                    if (wait_q == 24'd0) state_q <= INIT_CFG;
                end
                INIT_CFG: begin
                    {write_q, reg_q, wdata_q} <= {1'b1, 5'd0, 16'h3300};
                    op_q    <= OP_CFG;
                    state_q <= ISSUE;
                end
                IDLE: begin
                    // a waiting user request beats a due poll; the poll stays pending
                    if (bus.usr_valid) begin
                        {write_q, reg_q, wdata_q} <= {bus.usr_write, bus.usr_register, bus.usr_wdata};
                        op_q    <= OP_USR;
                        state_q <= ISSUE;
                    end else if (pending_q) begin
                        {write_q, reg_q, wdata_q} <= {1'b0, 5'd1, 16'h0};
                        pending_q <= expire;
                        op_q      <= OP_BMSR;
                        state_q   <= ISSUE;
                    end
                end
                ISSUE: if (bus.smi_ready) begin
                    valid_q <= 1'b1;
                    state_q <= WAIT_LOW;
                end
                WAIT_LOW: state_q <= WAIT_DONE;
                WAIT_DONE: if (bus.smi_ready) begin
                    case (op_q)
                        OP_RST: begin
                            wait_q  <= RST_WAIT_CYCLES - 24'd1;
                            state_q <= INIT_WAIT;
                        end
                        OP_CFG: state_q <= IDLE;
                        OP_BMSR: begin
                            link_tmp_q <= bus.smi_read_value[2];
                            {write_q, reg_q, wdata_q} <= {1'b0, 5'd31, 16'h0};
                            op_q    <= OP_PHYSTS;
                            state_q <= ISSUE;
                        end
                        OP_PHYSTS: begin
                            link_q   <= link_tmp_q;
                            speed_q  <= bus.smi_read_value[3];
                            duplex_q <= bus.smi_read_value[4];
                            status_q <= 1'b1;
                            state_q  <= IDLE;
                        end
                        default: begin
                            if (!write_q) rdata_q <= bus.smi_read_value;
                            done_q  <= 1'b1;
                            state_q <= IDLE;
                        end
                    endcase
                end
                default: state_q <= START;
            endcase
        end
    end
endmodule

// File: tb/tb_eth_phy_ctrl.sv
// tb_eth_phy_ctrl: randomized user traffic against an SMI register-file model and
// a transaction-level scoreboard for polling, arbitration and reset behaviour.
module tb_eth_phy_ctrl;
    localparam logic [4:0] PA    = 5'd9;
    localparam int         POLL  = 400;
    localparam int         RWAIT = 40;
`ifdef ETH_PHY_CTRL_INIT_EN
    localparam int         NI        = 2;
    localparam logic [4:0] FIRST_REG = 5'd0;
`else
    localparam int         NI        = 0;
    localparam logic [4:0] FIRST_REG = 5'd1;
`endif

    typedef struct {logic w; logic [4:0] r; logic [15:0] d; int at;} txn_t;

    logic clk_mac = 1'b0;
    logic rst = 1'b1;
    logic link_up, speed_100, full_duplex, status_valid;
    eth_phy_ctrl_if bus();

    eth_phy_ctrl #(.PHYADDR(PA), .POLL_CYCLES(24'(POLL)), .RST_WAIT_CYCLES(24'(RWAIT))) dut (
        .clk_mac(clk_mac), .rst(rst), .bus(bus),
        .link_up(link_up), .speed_100(speed_100), .full_duplex(full_duplex), .status_valid(status_valid)
    );

    always #5 clk_mac = ~clk_mac;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] dflt(input logic [4:0] r);
        return r == 5'd2 ? 16'h0007 : {3'b101, r, 3'b000, r};
    endfunction

    // SMI master model: 10-cycle ops over a register file; reg1/reg31 come from st1/st31
    logic        s_ready = 1'b1;
    logic [15:0] s_rdata = 16'h0;
    logic [15:0] mem [32];
    logic [31:0] wr_mask = '0;
    logic [15:0] st1, st31;
    logic [15:0] shadow [32];
    logic [15:0] last_rd = 16'h0;
    int   busy = 0, cyc = 0, polls = 0, caps1 = 0;
    int   last1_t = 0, prev1_t = 0, last31_t = 0;
    logic prev_valid = 1'b0, rst_q = 1'b1, in_poll = 1'b0, pend31 = 1'b0, status_due = 1'b0;
    logic exp_link = 1'b0, exp_sp = 1'b0, exp_fd = 1'b0;
    txn_t cap;
    txn_t txq[$];
    txn_t uq[$];

    assign bus.smi_ready      = s_ready;
    assign bus.smi_read_value = s_rdata;

    always @(posedge clk_mac) begin
        cyc        <= cyc + 1;
        prev_valid <= bus.smi_valid;
        rst_q      <= rst;
        status_due <= 1'b0;
        if (bus.smi_valid && s_ready) begin
            cap = '{w: bus.smi_write, r: bus.smi_register, d: bus.smi_write_value, at: cyc};
            txq.push_back(cap);
            if (cap.r != 5'd0 && cap.r != 5'd1 && cap.r != 5'd31) uq.push_back(cap);
            if (cap.w) begin
                mem[cap.r]     <= cap.d;
                wr_mask[cap.r] <= 1'b1;
            end
            s_rdata <= cap.r == 5'd1 ? st1 : cap.r == 5'd31 ? st31 : wr_mask[cap.r] ? mem[cap.r] : dflt(cap.r);
            s_ready <= 1'b0;
            busy    <= 10;
            if (!cap.w && cap.r == 5'd1) begin
                in_poll  <= 1'b1;
                exp_link <= st1[2];
                prev1_t  <= last1_t;
                last1_t  <= cyc;
                caps1    <= caps1 + 1;
            end
            if (!cap.w && cap.r == 5'd31) begin
                pend31   <= 1'b1;
                exp_sp   <= st31[3];
                exp_fd   <= st31[4];
                last31_t <= cyc;
            end
        end else begin
            if (busy > 1) busy <= busy - 1;
            else if (busy == 1) begin
                busy    <= 0;
                s_ready <= 1'b1;
            end
            if (s_ready && pend31 && !rst) begin
                pend31     <= 1'b0;
                in_poll    <= 1'b0;
                status_due <= 1'b1;
                polls      <= polls + 1;
            end
        end
        if (rst) begin
            in_poll <= 1'b0;
            pend31  <= 1'b0;
        end
    end

    always @(negedge clk_mac) begin
        if (bus.smi_valid) begin
            check("valid_without_ready", bus.smi_ready, 1'b1);
            check("valid_back_to_back", prev_valid, 1'b0);
            check("phyaddr", bus.smi_phyaddr, PA);
        end
        if (in_poll) check("usr_ready_in_poll", bus.usr_ready, 1'b0);
        if (rst_q) check("valid_in_rst", bus.smi_valid, 1'b0);
        if (status_due) begin
            check("status_link", link_up, exp_link);
            check("status_speed", speed_100, exp_sp);
            check("status_duplex", full_duplex, exp_fd);
            check("status_valid", status_valid, 1'b1);
        end
    end

    task automatic chk_reset(input string p);
        check({p, "_smi_valid"}, bus.smi_valid, 1'b0);
        check({p, "_smi_write"}, bus.smi_write, 1'b0);
        check({p, "_smi_phyaddr"}, bus.smi_phyaddr, 5'd0);
        check({p, "_smi_register"}, bus.smi_register, 5'd0);
        check({p, "_smi_wval"}, bus.smi_write_value, 16'h0);
        check({p, "_usr_ready"}, bus.usr_ready, 1'b0);
        check({p, "_usr_done"}, bus.usr_done, 1'b0);
        check({p, "_usr_rdata"}, bus.usr_rdata, 16'h0);
        check({p, "_link_up"}, link_up, 1'b0);
        check({p, "_speed_100"}, speed_100, 1'b0);
        check({p, "_full_duplex"}, full_duplex, 1'b0);
        check({p, "_status_valid"}, status_valid, 1'b0);
    endtask

    task automatic usr_op(input logic w, input logic [4:0] r, input logic [15:0] d);
        int n, sz;
        logic [15:0] exp;
        txn_t t;
        sz = uq.size();
        bus.usr_valid = 1'b1;
        bus.usr_write = w;
        bus.usr_register = r;
        bus.usr_wdata = d;
        #1;
        n = 0;
        while (!bus.usr_ready && n < 2000) begin
            @(negedge clk_mac);
            #1;
            n++;
        end
        check("usr_accept", n < 2000, 1'b1);
        @(negedge clk_mac);
        bus.usr_valid = 1'b0;
        n = 0;
        while (!bus.usr_done && n < 100) begin
            @(negedge clk_mac);
            n++;
        end
        check("usr_done", n < 100, 1'b1);
        exp = w ? last_rd : shadow[r];
        check(w ? "usr_rdata_after_write" : "usr_rdata_after_read", bus.usr_rdata, exp);
        if (w) shadow[r] = d;
        else last_rd = exp;
        check("usr_txn_count", uq.size(), sz + 1);
        if (uq.size() > 0) begin
            t = uq[$];
            check("usr_txn_write", t.w, w);
            check("usr_txn_reg", t.r, r);
            if (w) check("usr_txn_data", t.d, d);
        end
        @(negedge clk_mac);
        check("usr_done_pulse", bus.usr_done, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, k;
        for (int i = 0; i < 32; i++) shadow[i] = dflt(5'(i));
        st1 = 16'h782D;
        st31 = 16'h0058;
        bus.usr_valid = 1'b1;
        bus.usr_write = 1'b0;
        bus.usr_register = 5'd2;
        bus.usr_wdata = 16'h0;
        repeat (3) @(negedge clk_mac);
        chk_reset("rst0");
        rst = 1'b0;
        // user read held through reset collides with the pending first poll
        usr_op(1'b0, 5'd2, 16'h0);
        check("tie_rdata", bus.usr_rdata, 16'h0007);
        n = 0;
        while (polls < 1 && n < 500) begin
            @(negedge clk_mac);
            n++;
        end
        check("poll1_done", polls >= 1, 1'b1);
        check("txq_len", txq.size() >= NI + 3, 1'b1);
        if (txq.size() >= NI + 3) begin
            check("tie_user_first", txq[NI].r, 5'd2);
            check("tie_poll_bmsr", txq[NI + 1].r, 5'd1);
            check("tie_poll_physts", txq[NI + 2].r, 5'd31);
            check("tie_poll_read", txq[NI + 1].w | txq[NI + 2].w, 1'b0);
        end
`ifdef ETH_PHY_CTRL_INIT_EN
        if (txq.size() >= 2) begin
            check("init0", {txq[0].w, txq[0].r, txq[0].d}, {1'b1, 5'd0, 16'h8000});
            check("init1", {txq[1].w, txq[1].r, txq[1].d}, {1'b1, 5'd0, 16'h3300});
            check("init_gap", txq[1].at - txq[0].at >= RWAIT + 10, 1'b1);
        end
`endif
        check("poll1_link", link_up, 1'b1);
        check("poll1_speed", speed_100, 1'b1);
        check("poll1_duplex", full_duplex, 1'b1);
        check("poll1_valid", status_valid, 1'b1);

        // user request arriving between the two poll reads must wait
        n = 0;
        while (!in_poll && n < 2 * POLL) begin
            @(negedge clk_mac);
            n++;
        end
        check("mid_poll_seen", in_poll, 1'b1);
        usr_op(1'b0, 5'd7, 16'h0);
        if (uq.size() > 0) check("usr_after_physts", uq[$].at > last31_t, 1'b1);

        for (int i = 0; i < 30; i++) begin
            st1 = 16'($urandom);
            st31 = 16'($urandom);
            usr_op(1'($urandom_range(0, 1)), 5'($urandom_range(2, 30)), 16'($urandom));
            repeat ($urandom_range(0, 40)) @(negedge clk_mac);
        end

        k = caps1;
        n = 0;
        while (caps1 < k + 3 && n < 4 * POLL) begin
            @(negedge clk_mac);
            n++;
        end
        check("poll_periodic", caps1 >= k + 3, 1'b1);
        check("poll_interval", last1_t - prev1_t, POLL);

        // reset while a user read is outstanding in WAIT_DONE
        bus.usr_valid = 1'b1;
        bus.usr_write = 1'b0;
        bus.usr_register = 5'd5;
        #1;
        n = 0;
        while (!bus.usr_ready && n < 2000) begin
            @(negedge clk_mac);
            #1;
            n++;
        end
        @(negedge clk_mac);
        bus.usr_valid = 1'b0;
        n = 0;
        while (s_ready && n < 100) begin
            @(negedge clk_mac);
            n++;
        end
        check("abort_op_started", s_ready, 1'b0);
        repeat (3) @(negedge clk_mac);
        rst = 1'b1;
        @(negedge clk_mac);
        chk_reset("rst_mid");
        repeat (2) @(negedge clk_mac);
        rst = 1'b0;
        last_rd = 16'h0;

        k = polls;
        n = 0;
        while (polls == k && n < 2000) begin
            @(negedge clk_mac);
            n++;
        end
        check("poll_after_abort", polls > k, 1'b1);
        rst = 1'b1;
        repeat (2) @(negedge clk_mac);
        check("rst2_valid", bus.smi_valid, 1'b0);
        k = txq.size();
        rst = 1'b0;
        n = 0;
        while (!bus.smi_valid && n < 200) begin
            @(negedge clk_mac);
            n++;
        end
`ifndef ETH_PHY_CTRL_INIT_EN
        check("first_poll_latency", n, 2);
`endif
        @(negedge clk_mac);
        check("first_txn_seen", txq.size(), k + 1);
        if (txq.size() > k) check("first_txn_reg", txq[k].r, FIRST_REG);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/eth_phy_ctrl.md
ETH_PHY_CTRL -- requirements
Module: eth_phy_ctrl

Interface
REQ-001 Parameter PHYADDR, default 5'd1, SHALL be the PHY address used on every management transaction.
REQ-002 Parameter POLL_CYCLES, default 24'd5_000_000, SHALL be the clk_mac cycles between status poll starts.
REQ-003 Parameter RST_WAIT_CYCLES, default 24'd2_500_000, SHALL be the clk_mac cycles waited after the PHY soft-reset write.
REQ-004 clk_mac  in  1  SHALL be the single clock; all logic SHALL be synchronous to its rising edge.
REQ-005 rst  in  1  SHALL be a synchronous, active-high reset.
REQ-006 smi_ready  in  1  SHALL be the management master idle flag.
REQ-007 smi_valid  out  1  SHALL be a one-cycle transaction request.
REQ-008 smi_write  out  1  SHALL select write (1) or read (0).
REQ-009 smi_phyaddr  out  5  SHALL carry PHYADDR.
REQ-010 smi_register  out  5  SHALL carry the register address.
REQ-011 smi_write_value  out  16  SHALL carry the write data.
REQ-012 smi_read_value  in  16  SHALL carry the read result.
REQ-013 usr_valid  in  1  SHALL be the user request strobe, held until accepted.
REQ-014 usr_ready  out  1  SHALL be high when a user request is accepted this cycle if usr_valid is high.
REQ-015 usr_write / usr_register / usr_wdata  in  1/5/16  SHALL be the user op fields, sampled at acceptance.
REQ-016 usr_rdata  out  16  SHALL be the last user read result.
REQ-017 usr_done  out  1  SHALL pulse one cycle at user op completion.
REQ-018 link_up / speed_100 / full_duplex  out  1 each  SHALL be the latest polled PHY status.
REQ-019 status_valid  out  1  SHALL be high once a full poll has completed since reset.

Function
REQ-020 States: INIT_RST, INIT_WAIT, INIT_CFG, IDLE, ISSUE, WAIT_LOW, WAIT_DONE.
REQ-021 Transaction: in ISSUE with smi_ready=1, drive smi_valid=1 one cycle with stable fields -> WAIT_LOW (one cycle, smi_ready ignored) -> WAIT_DONE until smi_ready=1 -> completion.
REQ-022 smi_valid SHALL never be asserted while smi_ready=0 or in two consecutive cycles.
REQ-023 Field outputs SHALL be held from ISSUE through completion.
REQ-024 Poll timer: 24-bit down-counter reloaded with POLL_CYCLES-1 on expiry; expiry sets poll_pending, which stays set until the poll starts.
REQ-025 Poll: read reg 1 (BMSR), link_up <= bit 2; then read reg 31, speed_100 <= bit 3, full_duplex <= bit 4; status outputs and status_valid SHALL update together at second-read completion.
REQ-026 The two poll reads SHALL be back-to-back; a user request arriving between them SHALL wait.
REQ-027 In IDLE with usr_valid=1 and poll_pending=1 simultaneously, the user request SHALL win; the poll SHALL be deferred, never dropped.
REQ-028 usr_ready SHALL be high only in IDLE; acceptance moves to ISSUE the next cycle.
REQ-029 User read: usr_rdata <= smi_read_value and usr_done=1 in the completion cycle; user write: usr_done only, usr_rdata unchanged.
REQ-030 Timer expiry during an in-progress poll SHALL set poll_pending (one more poll follows), no queue deeper than one.

Reset
REQ-031 During rst: smi_valid=0, smi_write=0, fields=0, usr_ready=0, usr_done=0, usr_rdata=0, link_up=0, speed_100=0, full_duplex=0, status_valid=0, poll_pending=1, timer=POLL_CYCLES-1.
REQ-032 rst mid-transaction SHALL abandon it without a further smi_valid; state SHALL restart per REQ-033/034.

Configuration
REQ-033 With ETH_PHY_CTRL_INIT_EN defined: after reset, write reg 0 = 16'h8000, wait RST_WAIT_CYCLES, write reg 0 = 16'h3300, then IDLE; usr_ready=0 and polling suppressed until IDLE.
REQ-034 Without ETH_PHY_CTRL_INIT_EN: reset enters IDLE directly; first poll starts the first cycle after reset deasserts.

Verification
REQ-035 INIT_EN, SMI model 10-cycle ops: after reset -> writes (reg0,8000) then after RST_WAIT_CYCLES (reg0,3300), then read reg1, reg31.
REQ-036 Model returns reg1=16'h782D, reg31=16'h0058 -> link_up=1, speed_100=1, full_duplex=1, status_valid=1 after second read.
REQ-037 usr_valid and poll expiry same IDLE cycle, user read reg 2 returning 16'h0007 -> user op first, usr_rdata=0007, usr_done pulse, then poll reads.
REQ-038 usr_valid asserted between poll reads -> usr_ready stays 0 until reg31 read completes.
REQ-039 rst asserted during WAIT_DONE -> all outputs at REQ-031 values next cycle, no smi_valid during rst.
REQ-040 Check every cycle: smi_valid never with smi_ready=0, never two consecutive cycles.
